// File: rtl/ay_write_scheduler_pkg.sv
// rtl/ay_write_scheduler_pkg.sv - shared types and helpers for the AY write scheduler
package ay_write_scheduler_pkg;
  `include "ay_bus_defs.vh"

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_GAP_A = ST_GAP_A,
    S_DATA  = ST_DATA,
    S_GAP_D = ST_GAP_D
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ay_write_scheduler_if.sv
// rtl/ay_write_scheduler_if.sv - requester handshakes and AY bus outputs of the write scheduler
interface ay_write_scheduler_if;
  logic       req0_valid;
  logic [3:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       ay_bdir;
  logic       ay_bc1;
  logic [7:0] ay_din;
  logic       busy;
  logic       grant_id;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, ay_bdir, ay_bc1, ay_din, busy, grant_id
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, ay_bdir, ay_bc1, ay_din, busy, grant_id
  );
endinterface

// File: rtl/ay_bus_defs.vh
// rtl/ay_bus_defs.vh - AY bus codes ({bdir,bc1}) and write-scheduler FSM state encodings
localparam logic [1:0] AY_INACTIVE = 2'b00;
localparam logic [1:0] AY_WRITE    = 2'b10;
localparam logic [1:0] AY_LATCH    = 2'b11;

localparam logic [2:0] ST_IDLE  = 3'd0;
localparam logic [2:0] ST_ADDR  = 3'd1;
localparam logic [2:0] ST_GAP_A = 3'd2;
localparam logic [2:0] ST_DATA  = 3'd3;
localparam logic [2:0] ST_GAP_D = 3'd4;

// File: rtl/ay_write_scheduler_rr_arbiter2.sv
// rtl/ay_write_scheduler_rr_arbiter2.sv - two-way round-robin arbiter, ptr holds the last granted id
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/ay_write_scheduler.sv
// rtl/ay_write_scheduler.sv - shares one AY-3-8910 write port between two requesters
module ay_write_scheduler
  import ay_write_scheduler_pkg::*;
#(
  parameter int HOLD_TICKS = 2,
  parameter int GAP_TICKS  = 1
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 ce,
  ay_write_scheduler_if.slave bus
);
  localparam int HOLD_N = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int GAP_N  = (GAP_TICKS < 0) ? 0 : GAP_TICKS;
  localparam int CW     = $clog2(max2(HOLD_N, GAP_N) + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_N - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_N > 0) ? GAP_N - 1 : 0);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    addr_q, addr_n;
  logic [7:0]    data_q, data_n;
  logic          rr_ptr, rr_n;
  logic          gid_q, gid_n;
  logic          rdy0_q, rdy0_n, rdy1_q, rdy1_n;
  logic [1:0]    code_q, code_n;
  logic [7:0]    din_q, din_n;
  logic          busy_q, busy_n;
  logic [1:0]    grant;

  rr_arbiter2 u_arb (
    .valid ({bus.req1_valid, bus.req0_valid}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Every output is computed one cycle ahead and registered with the state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    data_n  = data_q;
    rr_n    = rr_ptr;
    gid_n   = gid_q;
    rdy0_n  = 1'b0;
    rdy1_n  = 1'b0;
    code_n  = code_q;
    din_n   = din_q;
    case (state)
      S_IDLE: begin
        if (grant != 2'b00) begin
          addr_n  = grant[1] ? bus.req1_addr : bus.req0_addr;
          data_n  = grant[1] ? bus.req1_data : bus.req0_data;
          gid_n   = grant[1];
          rr_n    = grant[1];
          rdy0_n  = grant[0];
          rdy1_n  = grant[1];
          state_n = S_ADDR;
          cnt_n   = '0;
          code_n  = AY_LATCH;
          din_n   = {4'b0000, addr_n};
        end
      end
      S_ADDR: begin
        if (ce) begin
          if (cnt == HOLD_LAST) begin
            cnt_n = '0;
            if (GAP_N > 0) begin
              state_n = S_GAP_A;
              code_n  = AY_INACTIVE;
            end else begin
              state_n = S_DATA;
              code_n  = AY_WRITE;
              din_n   = data_q;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_GAP_A: begin
        if (ce) begin
          if (cnt == GAP_LAST) begin
            cnt_n   = '0;
            state_n = S_DATA;
            code_n  = AY_WRITE;
            din_n   = data_q;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (ce) begin
          if (cnt == HOLD_LAST) begin
            cnt_n   = '0;
            code_n  = AY_INACTIVE;
            state_n = (GAP_N > 0) ? S_GAP_D : S_IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_GAP_D: begin
        if (ce) begin
          if (cnt == GAP_LAST) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        code_n  = AY_INACTIVE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      rr_ptr <= 1'b1;
      gid_q  <= 1'b0;
      rdy0_q <= 1'b0;
      rdy1_q <= 1'b0;
      code_q <= AY_INACTIVE;
      din_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      data_q <= data_n;
      rr_ptr <= rr_n;
      gid_q  <= gid_n;
      rdy0_q <= rdy0_n;
      rdy1_q <= rdy1_n;
      code_q <= code_n;
      din_q  <= din_n;
      busy_q <= busy_n;
    end
  end

  assign bus.req0_ready = rdy0_q;
  assign bus.req1_ready = rdy1_q;
  assign bus.ay_bdir    = code_q[1];
  assign bus.ay_bc1     = code_q[0];
  assign bus.ay_din     = din_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = gid_q;
endmodule

// File: tb/tb_ay_write_scheduler.sv
// tb/tb_ay_write_scheduler.sv - directed self-checking bench for ay_write_scheduler
module tb_ay_write_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce_a, ce_b;
  logic ce_auto = 1'b0;
  logic ce_man_en = 1'b0;
  logic ce_man = 1'b0;
  int   ce_div = 13;
  int   ce_cnt = 0;

  int n_tests = 0;
  int n_fail = 0;

  ay_write_scheduler_if a_if ();
  ay_write_scheduler_if b_if ();

  ay_write_scheduler #(.HOLD_TICKS(2), .GAP_TICKS(1)) u_dut_a (
    .clk(clk), .reset(reset), .ce(ce_a), .bus(a_if)
  );
  ay_write_scheduler #(.HOLD_TICKS(1), .GAP_TICKS(0)) u_dut_b (
    .clk(clk), .reset(reset), .ce(ce_b), .bus(b_if)
  );

  always #5 clk = ~clk;

  assign ce_a = ce_man_en ? ce_man : ce_auto;
  assign ce_b = 1'b1;

  always @(posedge clk) begin
    #1;
    if (ce_cnt >= ce_div - 1) begin
      ce_cnt  = 0;
      ce_auto = 1'b1;
    end else begin
      ce_cnt  = ce_cnt + 1;
      ce_auto = 1'b0;
    end
  end

  // Bus monitor, jt49 register model and segment recorder for DUT A.
  int         cyc = 0;
  logic       prev_busy = 1'b0;
  int         idle_start_cyc = 0;
  int         r1_gap = -1;
  int         rdy0_cnt = 0;
  int         rdy1_cnt = 0;
  logic       read_seen = 1'b0;
  logic       din_unstable = 1'b0;
  logic       rec_en = 1'b0;
  logic [3:0] latch_a = 4'h0;
  logic [7:0] regs [16] = '{default: 8'h00};
  logic [2:0] seg_key [$];
  logic [7:0] seg_din [$];
  int         seg_ce [$];
  int         grant_q [$];
  int         gid_q [$];

  always @(negedge clk) begin
    logic [2:0] key;
    cyc = cyc + 1;
    if (!a_if.busy && prev_busy) idle_start_cyc = cyc;
    prev_busy = a_if.busy;
    if (a_if.req0_ready) begin
      rdy0_cnt = rdy0_cnt + 1;
      grant_q.push_back(0);
      gid_q.push_back(int'(a_if.grant_id));
    end
    if (a_if.req1_ready) begin
      rdy1_cnt = rdy1_cnt + 1;
      r1_gap = cyc - idle_start_cyc;
      grant_q.push_back(1);
      gid_q.push_back(int'(a_if.grant_id));
    end
    if ((!a_if.ay_bdir && a_if.ay_bc1) || (!b_if.ay_bdir && b_if.ay_bc1)) read_seen = 1'b1;
    if (ce_a && a_if.ay_bdir && a_if.ay_bc1) latch_a = a_if.ay_din[3:0];
    if (ce_a && a_if.ay_bdir && !a_if.ay_bc1) regs[latch_a] = a_if.ay_din;
    key = {a_if.busy, a_if.ay_bdir, a_if.ay_bc1};
    if (rec_en) begin
      if (seg_key.size() == 0 || key != seg_key[seg_key.size()-1]) begin
        seg_key.push_back(key);
        seg_din.push_back(a_if.ay_din);
        seg_ce.push_back(ce_a ? 1 : 0);
      end else begin
        if (a_if.ay_din != seg_din[seg_din.size()-1]) din_unstable = 1'b1;
        if (ce_a) seg_ce[seg_ce.size()-1] = seg_ce[seg_ce.size()-1] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_readies(input int target, input string tag);
    int n = 0;
    while ((rdy0_cnt + rdy1_cnt) < target && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if ((rdy0_cnt + rdy1_cnt) < target) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk); #1;
    while (a_if.busy && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (a_if.busy) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic ce_pulse();
    ce_man = 1'b1;
    @(posedge clk); #1;
    ce_man = 1'b0;
  endtask

  logic [2:0] exp_key [5] = '{3'b111, 3'b100, 3'b110, 3'b100, 3'b000};
  logic [7:0] exp_din [5] = '{8'h07, 8'h07, 8'h38, 8'h38, 8'h38};
  int         exp_ce  [4] = '{2, 1, 2, 1};

  initial begin
    int base;
    int n;
    a_if.req0_valid = 0; a_if.req0_addr = 0; a_if.req0_data = 0;
    a_if.req1_valid = 0; a_if.req1_addr = 0; a_if.req1_data = 0;
    b_if.req0_valid = 0; b_if.req0_addr = 0; b_if.req0_data = 0;
    b_if.req1_valid = 0; b_if.req1_addr = 0; b_if.req1_data = 0;
    do_reset();

    check("rst_bdir", a_if.ay_bdir, 0);
    check("rst_bc1", a_if.ay_bc1, 0);
    check("rst_din", a_if.ay_din, 8'h00);
    check("rst_ready", {a_if.req1_ready, a_if.req0_ready}, 2'b00);
    check("rst_busy", a_if.busy, 0);
    check("rst_grant_id", a_if.grant_id, 0);

    // Single write with ce every 13 clocks.
    rec_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    base = rdy0_cnt + rdy1_cnt;
    a_if.req0_addr = 4'd7; a_if.req0_data = 8'h38; a_if.req0_valid = 1'b1;
    wait_readies(base + 1, "single_ready");
    a_if.req0_valid = 1'b0;
    wait_idle("single_idle");
    repeat (2) @(negedge clk);
    #1 rec_en = 1'b0;
    check("single_ready_cnt", rdy0_cnt + rdy1_cnt - base, 1);
    check("single_seg_cnt", seg_key.size(), 6);
    if (seg_key.size() >= 6) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("single_seg%0d_code", i + 1), seg_key[i+1], exp_key[i]);
        check($sformatf("single_seg%0d_din", i + 1), seg_din[i+1], exp_din[i]);
      end
      for (int i = 0; i < 4; i++)
        check($sformatf("single_seg%0d_ticks", i + 1), seg_ce[i+1], exp_ce[i]);
    end
    check("single_din_stable", din_unstable, 0);
    check("single_reg7", regs[7], 8'h38);

    // Tie: both requesters valid continuously.
    do_reset();
    base = grant_q.size();
    a_if.req0_addr = 4'd8; a_if.req0_data = 8'h0F; a_if.req0_valid = 1'b1;
    a_if.req1_addr = 4'd9; a_if.req1_data = 8'h1F; a_if.req1_valid = 1'b1;
    wait_readies(rdy0_cnt + rdy1_cnt + 4, "tie_ready");
    a_if.req0_valid = 1'b0;
    a_if.req1_valid = 1'b0;
    wait_idle("tie_idle");
    check("tie_grant_cnt", grant_q.size() - base, 4);
    if (grant_q.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("tie_grant%0d", i), grant_q[base+i], i % 2);
        check($sformatf("tie_grant_id%0d", i), gid_q[base+i], i % 2);
      end
    end
    check("tie_reg8", regs[8], 8'h0F);
    check("tie_reg9", regs[9], 8'h1F);

    // Late arrival of req1 while req0 is in DATA.
    do_reset();
    base = rdy0_cnt + rdy1_cnt;
    a_if.req0_addr = 4'd1; a_if.req0_data = 8'h11; a_if.req0_valid = 1'b1;
    wait_readies(base + 1, "late_ready0");
    a_if.req0_valid = 1'b0;
    n = 0;
    while (!(a_if.ay_bdir && !a_if.ay_bc1) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check("late_reached_data", {a_if.ay_bdir, a_if.ay_bc1}, 2'b10);
    base = rdy1_cnt;
    a_if.req1_addr = 4'd2; a_if.req1_data = 8'h22; a_if.req1_valid = 1'b1;
    wait_readies(rdy0_cnt + base + 1, "late_ready1");
    a_if.req1_valid = 1'b0;
    check("late_r1_after_idle", r1_gap, 1);
    check("late_grant_id", a_if.grant_id, 1);
    wait_idle("late_idle");
    check("late_reg1", regs[1], 8'h11);
    check("late_reg2", regs[2], 8'h22);

    // ce coincident with the ADDR entry edge is not counted.
    do_reset();
    ce_man_en = 1'b1;
    ce_man = 1'b0;
    @(posedge clk); #1;
    a_if.req0_addr = 4'd3; a_if.req0_data = 8'h33; a_if.req0_valid = 1'b1;
    ce_man = 1'b1;
    @(posedge clk); #1;
    ce_man = 1'b0;
    a_if.req0_valid = 1'b0;
    check("entry_addr", {a_if.ay_bdir, a_if.ay_bc1}, 2'b11);
    repeat (3) @(posedge clk);
    #1 check("entry_ce_low_hold", {a_if.ay_bdir, a_if.ay_bc1}, 2'b11);
    ce_pulse();
    check("entry_after_tick1", {a_if.ay_bdir, a_if.ay_bc1}, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    ce_pulse();
    check("entry_after_tick2", {a_if.busy, a_if.ay_bdir, a_if.ay_bc1}, 3'b100);
    check("entry_gap_din", a_if.ay_din, 8'h03);
    ce_div = 1;
    ce_man_en = 1'b0;
    wait_idle("entry_idle");
    check("entry_reg3", regs[3], 8'h33);

    // Reset during DATA loses the write.
    do_reset();
    ce_man_en = 1'b1;
    ce_man = 1'b0;
    @(posedge clk); #1;
    a_if.req0_addr = 4'd5; a_if.req0_data = 8'hAA; a_if.req0_valid = 1'b1;
    @(posedge clk); #1;
    a_if.req0_valid = 1'b0;
    ce_pulse();
    ce_pulse();
    ce_pulse();
    check("rstmid_in_data", {a_if.ay_bdir, a_if.ay_bc1, a_if.ay_din}, {2'b10, 8'hAA});
    base = rdy1_cnt;
    reset = 1'b1;
    a_if.req0_addr = 4'd6; a_if.req0_data = 8'h66; a_if.req0_valid = 1'b1;
    @(posedge clk); #1;
    check("rstmid_bus", {a_if.ay_bdir, a_if.ay_bc1, a_if.ay_din}, 10'h000);
    check("rstmid_busy", a_if.busy, 0);
    check("rstmid_ready", {a_if.req1_ready, a_if.req0_ready}, 2'b00);
    reset = 1'b0;
    check("rstmid_latched", latch_a, 4'd5);
    check("rstmid_reg5", regs[5], 8'h00);
    ce_man_en = 1'b0;
    ce_div = 13;
    wait_readies(rdy0_cnt + rdy1_cnt + 1, "rstmid_fresh");
    a_if.req0_valid = 1'b0;
    wait_idle("rstmid_idle");
    check("rstmid_no_r1", rdy1_cnt - base, 0);
    check("rstmid_reg6", regs[6], 8'h66);
    check("rstmid_reg5_after", regs[5], 8'h00);

    // HOLD_TICKS=1, GAP_TICKS=0, ce every clock: accept, ADDR, DATA, IDLE.
    @(posedge clk); #1;
    b_if.req0_addr = 4'd4; b_if.req0_data = 8'h44; b_if.req0_valid = 1'b1;
    @(posedge clk); #1;
    check("sweep_addr", {b_if.req0_ready, b_if.busy, b_if.ay_bdir, b_if.ay_bc1, b_if.ay_din}, {4'b1111, 8'h04});
    b_if.req0_valid = 1'b0;
    @(posedge clk); #1;
    check("sweep_data", {b_if.req0_ready, b_if.busy, b_if.ay_bdir, b_if.ay_bc1, b_if.ay_din}, {4'b0110, 8'h44});
    @(posedge clk); #1;
    check("sweep_idle", {b_if.busy, b_if.ay_bdir, b_if.ay_bc1}, 3'b000);
    check("sweep_din_held", b_if.ay_din, 8'h44);

    check("no_read_code", read_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
